eeg_pair_sequencer: RTL

Controller that sequences the DWT+RLE compression core over one frame of EEG samples held in on-chip sample memory. On a start command it reads sample pairs from memory and presents them to the core as input1/input2 under a valid/ready handshake. After the last data pair it issues flush pairs so the core's pipeline and run-length state drain. It then signals done. It sits between the sample buffer and the compression top, replacing the bench-driven pair feeding.

---
 rtl/eeg_pair_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/eeg_pair_sequencer.sv
// Frame sequencer: streams sample pairs from memory into the DWT+RLE core,
// then drains the core with zero flush pairs and pulses done.
module eeg_pair_sequencer #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 10,
    parameter int LEN_W        = 10,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [LEN_W-1:0]         pair_count,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [2*DATA_W-1:0]      mem_rd_data,
    output logic                     core_valid,
    input  logic                     core_ready,
    output logic signed [DATA_W-1:0] input1,
    output logic signed [DATA_W-1:0] input2,
    output logic                     core_flush,
    output logic [LEN_W:0]           pairs_sent
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0]     count_q, count_d;
    logic [LEN_W:0]       reads_q, reads_d;
    logic [LEN_W:0]       sent_q, sent_d;
    logic                 inflight_q, inflight_d;
    logic [2*DATA_W-1:0]  fifo0_q, fifo0_d;
    logic [2*DATA_W-1:0]  fifo1_q, fifo1_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0]           fcnt_q, fcnt_d;
    logic [FC_W-1:0]      flush_cnt_q, flush_cnt_d;

    logic                 pop;
    logic [1:0]           occ;
    logic [2*DATA_W-1:0]  head;

    assign mem_addr   = addr_q;
    assign pairs_sent = sent_q;
    assign head       = rd_ptr_q ? fifo1_q : fifo0_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            reads_q     <= '0;
            sent_q      <= '0;
            inflight_q  <= 1'b0;
            fifo0_q     <= '0;
            fifo1_q     <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            fcnt_q      <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            reads_q     <= reads_d;
            sent_q      <= sent_d;
            inflight_q  <= inflight_d;
            fifo0_q     <= fifo0_d;
            fifo1_q     <= fifo1_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fcnt_q      <= fcnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        reads_d     = reads_q;
        sent_d      = sent_q;
        inflight_d  = 1'b0;
        fifo0_d     = fifo0_q;
        fifo1_d     = fifo1_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fcnt_d      = fcnt_q;
        flush_cnt_d = flush_cnt_q;

        busy       = 1'b0;
        done       = 1'b0;
        mem_rd_en  = 1'b0;
        core_valid = 1'b0;
        core_flush = 1'b0;
        input1     = '0;
        input2     = '0;

        pop = (state_q == S_STREAM) && (fcnt_q != 2'd0) && core_ready;
        // Slots already committed next cycle: queued + arriving - leaving.
        occ = fcnt_q + {1'b0, inflight_q} - {1'b0, pop};

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    count_d     = pair_count;
                    reads_d     = '0;
                    sent_d      = '0;
                    rd_ptr_d    = 1'b0;
                    wr_ptr_d    = 1'b0;
                    fcnt_d      = '0;
                    flush_cnt_d = '0;
                    state_d     = (pair_count == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                busy       = 1'b1;
                core_valid = (fcnt_q != 2'd0);
                input1     = head[2*DATA_W-1:DATA_W];
                input2     = head[DATA_W-1:0];
                mem_rd_en  = (reads_q < {1'b0, count_q}) && (occ < 2'd2);
                inflight_d = mem_rd_en;
                if (mem_rd_en) begin
                    addr_d  = addr_q + 1'b1;
                    reads_d = reads_q + 1'b1;
                end
                if (inflight_q) begin
                    if (wr_ptr_q) fifo1_d = mem_rd_data;
                    else          fifo0_d = mem_rd_data;
                    wr_ptr_d = ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_d = ~rd_ptr_q;
                    sent_d   = sent_q + 1'b1;
                    if (sent_q + 1'b1 == {1'b0, count_q}) begin
                        state_d = S_FLUSH;
                    end
                end
                fcnt_d = fcnt_q + {1'b0, inflight_q} - {1'b0, pop};
            end
            S_FLUSH: begin
                busy       = 1'b1;
                core_valid = 1'b1;
                core_flush = 1'b1;
                if (core_ready) begin
                    if (flush_cnt_q == FC_W'(FLUSH_CYCLES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
